// File: rtl/palette_pkg.sv
// Shared types and constants for the palette engine.
// The fade feature is built only when PALETTE_FADE_EN is defined.
package palette_pkg;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  localparam logic [1:0] FADE_NONE = 2'b00;
  localparam logic [1:0] FADE_OUT  = 2'b01;
  localparam logic [1:0] FADE_IN   = 2'b10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    ST_BRIGHT,
    ST_FADE_OUT,
    ST_DARK,
    ST_FADE_IN
  } fade_state_t;

  // (c * (lvl+1)) >> 4 using an 8-bit product: lvl 15 is identity, lvl 0 is black
  function automatic logic [3:0] scale4(input logic [3:0] c, input logic [3:0] lvl);
    return 4'(({4'd0, c} * ({4'd0, lvl} + 8'd1)) >> 4);
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Fade sequencer: BRIGHT -> FADE_OUT -> DARK -> FADE_IN -> BRIGHT, one level
// step every FADE_DIV frame_start pulses. Instantiated only under PALETTE_FADE_EN.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int FADE_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       i_frame_start,
  input  logic [1:0] i_fade_cmd,
  output logic [3:0] o_level,
  output logic       o_fade_busy
);

  localparam logic [7:0] CNT_LAST = 8'(FADE_DIV - 1);

  fade_state_t r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_level;
  logic        r_busy;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_BRIGHT;
      r_cnt   <= '0;
      r_level <= LEVEL_MAX;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        // The command cycle never counts a coincident frame_start pulse.
        ST_BRIGHT: if (i_fade_cmd == FADE_OUT) begin
          r_state <= ST_FADE_OUT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        ST_DARK: if (i_fade_cmd == FADE_IN) begin
          r_state <= ST_FADE_IN;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        ST_FADE_OUT: if (i_frame_start) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_level - 4'd1;
            if (r_level == 4'd1) begin
              r_state <= ST_DARK;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_FADE_IN: if (i_frame_start) begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_level + 4'd1;
            if (r_level == LEVEL_MAX - 4'd1) begin
              r_state <= ST_BRIGHT;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_BRIGHT;
          r_cnt   <= '0;
          r_level <= LEVEL_MAX;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_level     = r_level;
  assign o_fade_busy = r_busy;

endmodule

// File: rtl/palette_engine.sv
// Banked RGB444 palette with a 2-stage lookup pipeline and optional frame-locked
// fade (enabled by defining PALETTE_FADE_EN; otherwise stage 2 is a plain register).
module palette_engine
  import palette_pkg::*;
#(
  parameter int IDX_W    = 3,
  parameter int BANKS    = 8,
  parameter int FADE_DIV = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_start,
  input  logic [$clog2(BANKS)-1:0] bank_sel,
  input  logic                     pix_valid,
  input  logic [IDX_W-1:0]         index,
  input  logic                     wr_en,
  input  logic [$clog2(BANKS)-1:0] wr_bank,
  input  logic [IDX_W-1:0]         wr_index,
  input  logic [11:0]              wr_rgb,
  input  logic [1:0]               fade_cmd,
  output logic                     fade_busy,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     rgb_valid
);

  localparam int BW      = $clog2(BANKS);
  localparam int ENTRIES = 2 ** IDX_W;

  rgb444_t       r_pal [BANKS][ENTRIES];
  logic [BW-1:0] r_disp_bank;
  rgb444_t       r_s1;
  rgb444_t       r_s2;
  logic [1:0]    r_vld_pipe;
  rgb444_t       w_s2;

  // Palette store; lookup below sees the pre-write value in a write cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < BANKS; b++)
        for (int e = 0; e < ENTRIES; e++)
          r_pal[b][e] <= '0;
    end else if (wr_en) begin
      r_pal[wr_bank][wr_index] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_disp_bank <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_vld_pipe  <= '0;
    end else begin
      if (frame_start) r_disp_bank <= bank_sel;
      r_s1       <= r_pal[r_disp_bank][index];
      r_s2       <= w_s2;
      r_vld_pipe <= {r_vld_pipe[0], pix_valid};
    end
  end

`ifdef PALETTE_FADE_EN
  logic [3:0] w_level;

  palette_fade_ctrl #(.FADE_DIV(FADE_DIV)) u_fade (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .i_frame_start(frame_start),
    .i_fade_cmd   (fade_cmd),
    .o_level      (w_level),
    .o_fade_busy  (fade_busy)
  );

  assign w_s2 = {scale4(r_s1.r, w_level), scale4(r_s1.g, w_level), scale4(r_s1.b, w_level)};
`else
  logic w_unused;

  assign w_unused  = &{1'b0, fade_cmd};
  assign fade_busy = 1'b0;
  assign w_s2      = r_s1;
`endif

  assign red       = r_s2.r;
  assign green     = r_s2.g;
  assign blue      = r_s2.b;
  assign rgb_valid = r_vld_pipe[1];

endmodule

// File: tb/tb_palette_engine.sv
// Bench for palette_engine: directed sequences, a vector table and random
// traffic checked against a behavioural model; fade checks under PALETTE_FADE_EN.
module tb_palette_engine;

  localparam int IDX_W    = 3;
  localparam int BANKS    = 8;
  localparam int FADE_DIV = 4;
`ifdef PALETTE_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  logic        Clk = 1'b0, Reset_n = 1'b1;
  logic        frame_start = 0, pix_valid = 0, wr_en = 0;
  logic [2:0]  bank_sel = 0, index = 0, wr_bank = 0, wr_index = 0;
  logic [11:0] wr_rgb = 0;
  logic [1:0]  fade_cmd = 0;
  logic        fade_busy, rgb_valid;
  logic [3:0]  red, green, blue;

  palette_engine #(.IDX_W(IDX_W), .BANKS(BANKS), .FADE_DIV(FADE_DIV)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .bank_sel(bank_sel),
    .pix_valid(pix_valid), .index(index), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_index(wr_index), .wr_rgb(wr_rgb), .fade_cmd(fade_cmd), .fade_busy(fade_busy),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0, n_err = 0;

  // Behavioural model: mode 0 bright, 1 fading out, 2 dark, 3 fading in
  logic [11:0] m_pal [BANKS][2**IDX_W];
  int          m_disp, m_lvl, m_mode, m_frames;
  logic [11:0] m_s1, m_out;
  logic        m_v1, m_v2;

  function automatic logic [11:0] scale(input logic [11:0] c, input int lvl);
    int r, g, b;
    r = int'(c[11:8]) * (lvl + 1) / 16;
    g = int'(c[7:4])  * (lvl + 1) / 16;
    b = int'(c[3:0])  * (lvl + 1) / 16;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++)
      for (int e = 0; e < 2**IDX_W; e++) m_pal[b][e] = 12'h000;
    m_disp = 0; m_lvl = 15; m_mode = 0; m_frames = 0;
    m_s1 = 0; m_out = 0; m_v1 = 0; m_v2 = 0;
  endtask

  task automatic model_step();
    m_out = scale(m_s1, m_lvl);
    m_v2  = m_v1;
    m_s1  = m_pal[m_disp][index];
    m_v1  = pix_valid;
    if (wr_en) m_pal[wr_bank][wr_index] = wr_rgb;
    if (frame_start) m_disp = int'(bank_sel);
    if (FADE_EN) begin
      if (m_mode == 0 && fade_cmd == 2'b01) begin
        m_mode = 1; m_frames = 0;
      end else if (m_mode == 2 && fade_cmd == 2'b10) begin
        m_mode = 3; m_frames = 0;
      end else if ((m_mode == 1 || m_mode == 3) && frame_start) begin
        m_frames++;
        if (m_frames == FADE_DIV) begin
          m_frames = 0;
          m_lvl += (m_mode == 1) ? -1 : 1;
          if (m_lvl == 0)  m_mode = 2;
          if (m_lvl == 15) m_mode = 0;
        end
      end
    end
  endtask

  // One clock with model comparison of every output.
  task automatic cyc();
    logic eb;
    model_step();
    @(posedge Clk); #1;
    eb = (m_mode == 1 || m_mode == 3);
    n_vec++;
    if ({red, green, blue} !== m_out || rgb_valid !== m_v2 || fade_busy !== eb) begin
      n_err++;
      $display("FAIL model t=%0t: got rgb=%h v=%b busy=%b, want rgb=%h v=%b busy=%b",
               $time, {red, green, blue}, rgb_valid, fade_busy, m_out, m_v2, eb);
    end
  endtask

  task automatic chk_rgb(input string nm, input logic [11:0] e, input logic ev);
    n_vec++;
    if ({red, green, blue} !== e || rgb_valid !== ev) begin
      n_err++;
      $display("FAIL %s: got rgb=%h v=%b, want rgb=%h v=%b", nm, {red, green, blue}, rgb_valid, e, ev);
    end
  endtask

  task automatic chk_busy(input string nm, input logic e);
    n_vec++;
    if (fade_busy !== e) begin
      n_err++;
      $display("FAIL %s: got busy=%b, want busy=%b", nm, fade_busy, e);
    end
  endtask

  task automatic idle();
    frame_start = 0; pix_valid = 0; wr_en = 0; fade_cmd = 2'b00;
  endtask

  task automatic do_reset(input string nm);
    Reset_n = 1'b0;
    #1;
    chk_rgb(nm, 12'h000, 1'b0);
    chk_busy(nm, 1'b0);
    model_reset();
    idle();
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic wr(input int b, input int i, input logic [11:0] c);
    idle(); wr_en = 1; wr_bank = 3'(b); wr_index = 3'(i); wr_rgb = c; cyc(); idle();
  endtask

  task automatic frame(input int b);
    idle(); frame_start = 1; bank_sel = 3'(b); cyc(); idle(); cyc();
  endtask

  // Issue a read and advance until its result sits on the outputs.
  task automatic rd(input int i);
    idle(); pix_valid = 1; index = 3'(i); cyc(); idle(); cyc();
  endtask

  typedef struct {
    int          bank;
    int          idx;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 0, 12'hFFF};
    tbl[1] = '{7, 7, 12'h000};
    tbl[2] = '{0, 7, 12'h159};
    tbl[3] = '{7, 0, 12'hE2D};
    tbl[4] = '{3, 4, 12'h8F1};
    tbl[5] = '{5, 2, 12'h0A0};
    tbl[6] = '{6, 6, 12'h7C3};
    tbl[7] = '{4, 1, 12'hF0F};

    #1;
    do_reset("reset_init");

    // Lookup latency and bank/data path
    wr(2, 5, 12'hA3C);
    frame(2);
    rd(5);
    chk_rgb("bank2_idx5", 12'hA3C, 1'b1);

    // bank_sel only takes effect on frame_start
    wr(1, 5, 12'h5B7);
    bank_sel = 3'd1;
    rd(5);
    chk_rgb("midframe_bank_hold", 12'hA3C, 1'b1);
    frame(1);
    rd(5);
    chk_rgb("next_frame_bank1", 12'h5B7, 1'b1);

    // Same-cycle write and read returns the old value
    wr(1, 3, 12'h123);
    idle(); wr_en = 1; wr_bank = 3'd1; wr_index = 3'd3; wr_rgb = 12'hFFF;
    pix_valid = 1; index = 3'd3; cyc();
    idle(); pix_valid = 1; index = 3'd3; cyc();
    chk_rgb("rw_same_cycle_old", 12'h123, 1'b1);
    idle(); cyc();
    chk_rgb("rw_next_read_new", 12'hFFF, 1'b1);

    // Vector table
    foreach (tbl[k]) wr(tbl[k].bank, tbl[k].idx, tbl[k].rgb);
    foreach (tbl[k]) begin
      frame(tbl[k].bank);
      rd(tbl[k].idx);
      chk_rgb($sformatf("tbl%0d", k), tbl[k].rgb, 1'b1);
    end

    // Reset mid-pipeline clears outputs immediately
    idle(); pix_valid = 1; index = 3'd0; cyc();
    do_reset("reset_midpipe");

`ifdef PALETTE_FADE_EN
    wr(0, 0, 12'hF84);
    idle(); fade_cmd = 2'b01; cyc();
    chk_busy("fadeout_accept", 1'b1);
    for (int f = 0; f < 4; f++) frame(0);
    rd(0);
    chk_rgb("fade_level14", 12'hE73, 1'b1);
    for (int f = 0; f < 56; f++) frame(0);
    chk_busy("dark_not_busy", 1'b0);
    rd(0);
    chk_rgb("dark_black", 12'h000, 1'b1);
    idle(); fade_cmd = 2'b01; cyc();
    chk_busy("fadeout_ignored_dark", 1'b0);
    idle(); fade_cmd = 2'b10; cyc();
    chk_busy("fadein_accept", 1'b1);
    for (int f = 0; f < 28; f++) frame(0);
    rd(0);
    chk_rgb("fadein_level7", 12'h742, 1'b1);
    do_reset("reset_midfade");
    wr(0, 0, 12'hF84);
    idle(); fade_cmd = 2'b10; cyc();
    chk_busy("fadein_ignored_bright", 1'b0);
    rd(0);
    chk_rgb("post_reset_level15", 12'hF84, 1'b1);
    // Command coinciding with frame_start does not count that pulse
    idle(); fade_cmd = 2'b01; frame_start = 1; cyc();
    for (int f = 0; f < 3; f++) frame(0);
    rd(0);
    chk_rgb("cmd_frame_not_counted", 12'hF84, 1'b1);
    frame(0);
    rd(0);
    chk_rgb("cmd_frame_4th_step", 12'hE73, 1'b1);
    do_reset("reset_pre_random");
`else
    wr(0, 0, 12'hF84);
    idle(); fade_cmd = 2'b01; cyc();
    chk_busy("nofade_cmd_ignored", 1'b0);
    for (int f = 0; f < 100; f++) begin
      idle(); fade_cmd = 2'b01; frame_start = 1; bank_sel = 3'd0; cyc();
      idle(); fade_cmd = 2'b01; cyc();
    end
    chk_busy("nofade_busy_100", 1'b0);
    rd(0);
    chk_rgb("nofade_unscaled", 12'hF84, 1'b1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      wr_en       = ($urandom_range(0, 9) < 3);
      wr_bank     = 3'($urandom);
      wr_index    = 3'($urandom);
      wr_rgb      = 12'($urandom);
      frame_start = ($urandom_range(0, 3) == 0);
      bank_sel    = 3'($urandom);
      pix_valid   = 1'($urandom);
      index       = 3'($urandom);
      fade_cmd    = 2'($urandom);
      cyc();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
